// File: rtl/gelu_poly_scheduler.sv
// Packet-granular round-robin scheduler sharing one non-stallable GELU polynomial unit
// between two requesters; results return through credit-protected per-requester FIFOs.
module gelu_poly_scheduler #(
   parameter int W          = 32,
   parameter int LAT        = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic signed [W-1:0] req0_data,
   input  logic                req0_last,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic signed [W-1:0] req1_data,
   input  logic                req1_last,
   output logic                pu_valid_in,
   output logic signed [W-1:0] pu_xi_q,
   input  logic                pu_valid_out,
   input  logic signed [W-1:0] pu_s_xi_q,
   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic signed [W-1:0] rsp0_data,
   output logic                rsp0_last,
   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic signed [W-1:0] rsp1_data,
   output logic                rsp1_last,
   output logic                busy,
   output logic                err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + LAT + 1) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;

   state_t              state, state_nxt;
   logic                rr, rr_nxt;
   logic                issue, issue_id, issue_last;
   logic signed [W-1:0] issue_data;
   logic [LAT-1:0]      tag_v, tag_id, tag_last;
   logic [CW-1:0]       inflight [2];
   logic [AW:0]         occ [2];
   logic [AW-1:0]       wptr [2];
   logic [AW-1:0]       rptr [2];
   logic [W:0]          mem [2][FIFO_DEPTH];
   logic [1:0]          credit_ok, push, pop;

   always_comb begin
      inflight[0] = '0;
      inflight[1] = '0;
      for (int i = 0; i < LAT; i++) begin
         if (tag_v[i] && !tag_id[i]) inflight[0] = inflight[0] + CW'(1);
         if (tag_v[i] &&  tag_id[i]) inflight[1] = inflight[1] + CW'(1);
      end
   end

   // Credit counts FIFO slots not yet owned by stored or in-flight results.
   assign credit_ok[0] = (CW'(occ[0]) + inflight[0]) < CW'(FIFO_DEPTH);
   assign credit_ok[1] = (CW'(occ[1]) + inflight[1]) < CW'(FIFO_DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         rr    <= 1'b0;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_nxt     = rr;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      issue      = 1'b0;
      issue_id   = 1'b0;
      issue_last = 1'b0;
      issue_data = '0;
      case (state)
         IDLE: begin
            if (!rr) begin
               if (req0_valid)      state_nxt = SERVE0;
               else if (req1_valid) state_nxt = SERVE1;
            end else begin
               if (req1_valid)      state_nxt = SERVE1;
               else if (req0_valid) state_nxt = SERVE0;
            end
         end
         SERVE0: begin
            req0_ready = credit_ok[0];
            if (req0_valid && credit_ok[0]) begin
               issue      = 1'b1;
               issue_last = req0_last;
               issue_data = req0_data;
               if (req0_last) begin
                  rr_nxt    = 1'b1;
                  state_nxt = req1_valid ? SERVE1 : IDLE;
               end
            end
         end
         SERVE1: begin
            req1_ready = credit_ok[1];
            if (req1_valid && credit_ok[1]) begin
               issue      = 1'b1;
               issue_id   = 1'b1;
               issue_last = req1_last;
               issue_data = req1_data;
               if (req1_last) begin
                  rr_nxt    = 1'b0;
                  state_nxt = req0_valid ? SERVE0 : IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pu_valid_in = issue;
   assign pu_xi_q     = issue_data;

   // Tag pipe: stage LAT-1 lines up with pu_valid_out of the same element.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_v <= '0;
      end else begin
         tag_v[0] <= issue;
         for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_id[0]   <= issue_id;
      tag_last[0] <= issue_last;
      for (int i = 1; i < LAT; i++) begin
         tag_id[i]   <= tag_id[i-1];
         tag_last[i] <= tag_last[i-1];
      end
   end

   assign push[0] = pu_valid_out & tag_v[LAT-1] & ~tag_id[LAT-1];
   assign push[1] = pu_valid_out & tag_v[LAT-1] &  tag_id[LAT-1];
   assign pop[0]  = rsp0_valid & rsp0_ready;
   assign pop[1]  = rsp1_valid & rsp1_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 2; r++) begin
            occ[r]  <= '0;
            wptr[r] <= '0;
            rptr[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (push[r]) wptr[r] <= wptr[r] + AW'(1);
            if (pop[r])  rptr[r] <= rptr[r] + AW'(1);
            if (push[r] && !pop[r])      occ[r] <= occ[r] + (AW+1)'(1);
            else if (!push[r] && pop[r]) occ[r] <= occ[r] - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (push[r]) mem[r][wptr[r]] <= {tag_last[LAT-1], pu_s_xi_q};
      end
   end

   // A strobe without a tag (or a tag without a strobe) means the unit lost sync.
   always_ff @(posedge clk) begin
      if (!rst_n)                              err <= 1'b0;
      else if (pu_valid_out != tag_v[LAT-1])   err <= 1'b1;
   end

   assign rsp0_valid = (occ[0] != '0);
   assign rsp1_valid = (occ[1] != '0);
   assign rsp0_data  = mem[0][rptr[0]][W-1:0];
   assign rsp0_last  = mem[0][rptr[0]][W];
   assign rsp1_data  = mem[1][rptr[1]][W-1:0];
   assign rsp1_last  = mem[1][rptr[1]][W];

   assign busy = (state != IDLE) | (|tag_v) | rsp0_valid | rsp1_valid;

endmodule
